vga_scan_ctrl: RTL and testbench
================================

# vga_scan_ctrl

Display-side scan controller for the 640x480 pipeline. Runs entirely on the 25 MHz pixel clock and generates 640x480@60 VGA timing. It drives the read address into the frame-buffer BRAM read port (19-bit address, 12-bit RGB444 data), then re-aligns the returned pixel data with delayed sync signals. Its outputs are the VGA pins: 4-bit R/G/B, HSYNC and VSYNC.

## Interface
Parameters:
- DW, 12: pixel width, RGB444 packed {R[11:8], G[7:4], B[3:0]}
- RD_LAT, 1: frame-buffer read latency in cycles, from address to data; legal range 1-3
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal timing in pixels
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical timing in lines

Ports:
- i_clk25m  in  1  pixel clock, the only clock
- i_rstn  in  1  reset, asynchronous assert, active-low
- o_vga_addr  out  19  frame-buffer read address
- i_vga_data  in  DW  frame-buffer read data, valid RD_LAT cycles after address
- o_vga_r / o_vga_g / o_vga_b  out  4 each  pixel colour
- o_vga_hsync  out  1  horizontal sync, active-low
- o_vga_vsync  out  1  vertical sync, active-low
- o_frame_start  out  1  one-cycle pulse coincident with pixel (0,0) at the pins

## Operation
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..524, and wraps to 0.
- active = (h_cnt < 640) && (v_cnt < 480).
- hsync_raw is low for h_cnt in 656..751. vsync_raw is low for v_cnt in 490..491.
- Address counter (19 bit) generation, no multiplier:
  - Increments by 1 on every active cycle and holds during blanking.
  - Clears to 0 when h_cnt==799 and v_cnt==524.
  - Never exceeds 307199.
- o_vga_addr is registered. It presents the address of pixel (h_cnt, v_cnt) one cycle after the counters reach it.
- active, hsync_raw, vsync_raw and the frame-start flag (h_cnt==0 && v_cnt==0) are delayed through a shift register of depth 1+RD_LAT, then registered once more at the output.
- Output stage: RGB = delayed_active ? i_vga_data fields : 0. Blanking is forced black regardless of BRAM content.
- No handshake. The block free-runs from reset release and never stalls.

## Timing
- Reset values, held while i_rstn low:
  - h_cnt = 0, v_cnt = 0, address = 0
  - o_vga_addr = 0
  - RGB = 0
  - o_vga_hsync = 1, o_vga_vsync = 1
  - o_frame_start = 0
  - all delay stages cleared to inactive/deasserted
- Reset mid-frame: outputs go to reset values immediately. The first cycle after release restarts at (0,0). No partial-line recovery.
- Counter to pins latency: 2+RD_LAT cycles; 3 cycles at RD_LAT=1. Colour, syncs and o_frame_start are mutually aligned at the pins.
- Line = 800 cycles. Frame = 525 lines = 420000 cycles.
- hsync pulse: 96 cycles. vsync pulse: 2 lines = 1600 cycles.
- o_frame_start period: exactly 420000 cycles.
- Boundaries:
  - Last active pixel (639,479) has address 307199.
  - Next active pixel (0,0) of the following frame has address 0.
  - Address is unchanged across blanking, e.g. the value 639 is held from (639,0) through (799,0), then 640 at (0,1).

## Structure
- Package vga_pkg holds the 640x480@60 timing constants (H_/V_ values, H_TOTAL=800, V_TOTAL=525, FB_DEPTH=307200) and the RGB444 field positions. Parameters default to these constants.
- One sub-module, vga_pipe_delay, is natural: a parameterised-depth, parameterised-width shift register with async active-low clear. It is instantiated once for the bundle {active, hsync, vsync, frame_start}.

## Test plan
- Reset release -> o_vga_addr=0 on the 1st cycle after the first clock edge. Pins show hsync=vsync=1, RGB=0. o_frame_start pulses at cycle 3 with RD_LAT=1.
- BRAM model returning data=address[11:0] with 1-cycle latency -> pixel (5,0) shows R/G/B = 0/0/5 at the pins. Every blanking cycle shows 0 even when the model drives 12'hFFF.
- Full frame -> count of o_frame_start intervals = 420000 cycles. hsync low exactly 96 cycles per 800. vsync low exactly 1600 cycles per frame, starting at line 490.
- Address sweep over 2 frames -> reaches 307199 once per frame, returns to 0 at the next (0,0), and holds during horizontal blanking (639 over 161 cycles on line 0).
- Assert i_rstn low at (320,240) for 7 cycles -> outputs take reset values asynchronously, before the next clock edge. After release the scan restarts at address 0 with aligned syncs.
- RD_LAT=3 build -> pipe depth 4. Colour/sync alignment holds at the pins, with latency 5 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// Timing constants, RGB444 field layout and shared types for the 640x480@60 scan path.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;

    localparam int DW_RGB = 12;
    localparam int ADDR_W = 19;
    localparam int CNT_W  = 10;
    localparam int CH_W   = 4;
    localparam int R_LSB  = 8;
    localparam int G_LSB  = 4;
    localparam int B_LSB  = 0;

    // Syncs travel active-high so a cleared delay stage reads as "no pulse".
    typedef struct packed {
        logic active;
        logic hsync_pulse;
        logic vsync_pulse;
        logic frame_start;
    } scan_flags_t;

    function automatic logic in_span(input logic [CNT_W-1:0] cnt, input int lo, input int len);
        return (cnt >= CNT_W'(lo)) && (cnt < CNT_W'(lo + len));
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register with asynchronous active-low clear.
module vga_pipe_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per clock; reset clears every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= WIDTH'(0);
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: raster counters, frame-buffer read address, and sync/pixel
// re-alignment behind the frame-buffer read latency.
module vga_scan_ctrl #(
    parameter int DW       = vga_pkg::DW_RGB,
    parameter int RD_LAT   = 1,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic                       i_clk25m,
    input  logic                       i_rstn,
    output logic [vga_pkg::ADDR_W-1:0] o_vga_addr,
    input  logic [DW-1:0]              i_vga_data,
    output logic [vga_pkg::CH_W-1:0]   o_vga_r,
    output logic [vga_pkg::CH_W-1:0]   o_vga_g,
    output logic [vga_pkg::CH_W-1:0]   o_vga_b,
    output logic                       o_vga_hsync,
    output logic                       o_vga_vsync,
    output logic                       o_frame_start
);
    import vga_pkg::scan_flags_t;
    import vga_pkg::in_span;

    localparam int CW         = vga_pkg::CNT_W;
    localparam int AW         = vga_pkg::ADDR_W;
    localparam int CH         = vga_pkg::CH_W;
    localparam int H_TOT      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int ADDR_MAX   = H_ACTIVE * V_ACTIVE - 1;
    localparam int PIPE_DEPTH = 1 + RD_LAT;

    logic [CW-1:0] h_cnt_r, v_cnt_r, h_cnt_next_s, v_cnt_next_s;
    logic [AW-1:0] addr_cnt_r, addr_cnt_next_s;
    logic          h_last_s, v_last_s, addr_inc_s;
    scan_flags_t   flags_s, flags_dly_s;
    logic [DW-1:0] pixel_s;

    // Decode the current raster position into flags and the address-advance condition.
    always_comb begin
        h_last_s              = (h_cnt_r == CW'(H_TOT - 1));
        v_last_s              = (v_cnt_r == CW'(V_TOT - 1));
        flags_s.active        = (h_cnt_r < CW'(H_ACTIVE)) && (v_cnt_r < CW'(V_ACTIVE));
        flags_s.hsync_pulse   = in_span(h_cnt_r, H_ACTIVE + H_FP, H_SYNC);
        flags_s.vsync_pulse   = in_span(v_cnt_r, V_ACTIVE + V_FP, V_SYNC);
        flags_s.frame_start   = (h_cnt_r == CW'(0)) && (v_cnt_r == CW'(0));
        // Address of the next position: step within a line, and step again at the line
        // wrap so blanking holds the last active address of the line.
        addr_inc_s = ((flags_s.active && (h_cnt_r != CW'(H_ACTIVE - 1)))
                      || (h_last_s && (v_cnt_r < CW'(V_ACTIVE - 1))))
                     && (addr_cnt_r != AW'(ADDR_MAX));
    end

    // Next raster position and read address.
    always_comb begin
        h_cnt_next_s    = h_cnt_r + CW'(1);
        v_cnt_next_s    = v_cnt_r;
        addr_cnt_next_s = addr_cnt_r;
        if (h_last_s) begin
            h_cnt_next_s = CW'(0);
            if (v_last_s) begin
                v_cnt_next_s = CW'(0);
            end else begin
                v_cnt_next_s = v_cnt_r + CW'(1);
            end
        end else begin
            h_cnt_next_s = h_cnt_r + CW'(1);
        end
        if (h_last_s && v_last_s) begin
            addr_cnt_next_s = AW'(0);
        end else if (addr_inc_s) begin
            addr_cnt_next_s = addr_cnt_r + AW'(1);
        end else begin
            addr_cnt_next_s = addr_cnt_r;
        end
    end

    // Raster and address state.
    always_ff @(posedge i_clk25m or negedge i_rstn) begin
        if (!i_rstn) begin
            h_cnt_r    <= CW'(0);
            v_cnt_r    <= CW'(0);
            addr_cnt_r <= AW'(0);
        end else begin
            h_cnt_r    <= h_cnt_next_s;
            v_cnt_r    <= v_cnt_next_s;
            addr_cnt_r <= addr_cnt_next_s;
        end
    end

    vga_pipe_delay #(
        .DEPTH (PIPE_DEPTH),
        .WIDTH ($bits(scan_flags_t))
    ) u_flag_dly (
        .clk   (i_clk25m),
        .rst_n (i_rstn),
        .d     (flags_s),
        .q     (flags_dly_s)
    );

    // Blanking is forced black whatever the frame buffer returns.
    always_comb begin
        if (flags_dly_s.active) begin
            pixel_s = i_vga_data;
        end else begin
            pixel_s = DW'(0);
        end
    end

    // Output registers: address one cycle after the counters, pins aligned with returned data.
    always_ff @(posedge i_clk25m or negedge i_rstn) begin
        if (!i_rstn) begin
            o_vga_addr    <= AW'(0);
            o_vga_r       <= CH'(0);
            o_vga_g       <= CH'(0);
            o_vga_b       <= CH'(0);
            o_vga_hsync   <= 1'b1;
            o_vga_vsync   <= 1'b1;
            o_frame_start <= 1'b0;
        end else begin
            o_vga_addr    <= addr_cnt_r;
            o_vga_r       <= pixel_s[vga_pkg::R_LSB +: CH];
            o_vga_g       <= pixel_s[vga_pkg::G_LSB +: CH];
            o_vga_b       <= pixel_s[vga_pkg::B_LSB +: CH];
            o_vga_hsync   <= ~flags_dly_s.hsync_pulse;
            o_vga_vsync   <= ~flags_dly_s.vsync_pulse;
            o_frame_start <= flags_dly_s.frame_start;
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench: a full-size RD_LAT=1 instance and a shrunken-raster RD_LAT=3 instance.
module tb_vga_scan_ctrl;

    typedef struct packed {
        int ha; int hfp; int hsw; int hbp; int va; int vfp; int vsw; int vbp;
    } tim_t;

    typedef struct packed {
        logic [18:0] addr;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        act;
    } exp_t;

    localparam tim_t TA    = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam tim_t TS    = '{8, 2, 3, 3, 4, 1, 2, 1};
    localparam int   LAT_A = 3;
    localparam int   LAT_S = 5;
    localparam exp_t IDLE  = '{addr: 19'd0, r: 4'd0, g: 4'd0, b: 4'd0,
                               hs: 1'b1, vs: 1'b1, fs: 1'b0, act: 1'b0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] addr_a, addr_s;
    logic [11:0] data_a, data_s, ds1, ds2;
    logic [3:0]  r_a, g_a, b_a, r_s, g_s, b_s;
    logic        hs_a, vs_a, fs_a, hs_s, vs_s, fs_s;
    logic        cur_act_a, cur_act_s;
    logic        started_a, started_s;
    logic        finishing;
    int          chk_n = 0;
    int          err_n = 0;
    exp_t        qa_pin[$], qa_addr[$], qs_pin[$], qs_addr[$];

    always #5 clk = ~clk;

    vga_scan_ctrl #(.RD_LAT(1)) dut_a (
        .i_clk25m(clk), .i_rstn(rst_n), .o_vga_addr(addr_a), .i_vga_data(data_a),
        .o_vga_r(r_a), .o_vga_g(g_a), .o_vga_b(b_a),
        .o_vga_hsync(hs_a), .o_vga_vsync(vs_a), .o_frame_start(fs_a)
    );

    vga_scan_ctrl #(
        .RD_LAT(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .i_clk25m(clk), .i_rstn(rst_n), .o_vga_addr(addr_s), .i_vga_data(data_s),
        .o_vga_r(r_s), .o_vga_g(g_s), .o_vga_b(b_s),
        .o_vga_hsync(hs_s), .o_vga_vsync(vs_s), .o_frame_start(fs_s)
    );

    // Frame-buffer models: data = address[11:0] for active pixels, 12'hFFF otherwise.
    always @(posedge clk) data_a <= cur_act_a ? addr_a[11:0] : 12'hFFF;
    always @(posedge clk) begin
        ds1    <= cur_act_s ? addr_s[11:0] : 12'hFFF;
        ds2    <= ds1;
        data_s <= ds2;
    end

    function automatic exp_t model(input tim_t t, input int h, input int v);
        exp_t e;
        int   a;
        e.act = (h < t.ha) && (v < t.va);
        if (v >= t.va)      a = t.ha * t.va - 1;
        else if (h >= t.ha) a = v * t.ha + t.ha - 1;
        else                a = v * t.ha + h;
        e.addr = 19'(a);
        e.r    = e.act ? 4'(a >> 8) : 4'd0;
        e.g    = e.act ? 4'(a >> 4) : 4'd0;
        e.b    = e.act ? 4'(a)      : 4'd0;
        e.hs   = !((h >= t.ha + t.hfp) && (h < t.ha + t.hfp + t.hsw));
        e.vs   = !((v >= t.va + t.vfp) && (v < t.va + t.vfp + t.vsw));
        e.fs   = (h == 0) && (v == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Producer: one expected entry per clock from the bench's own raster model.
    initial begin
        int   ha, va, hs, vs;
        exp_t e;
        ha = 0; va = 0; hs = 0; vs = 0;
        started_a = 1'b0; started_s = 1'b0;
        cur_act_a <= 1'b0; cur_act_s <= 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                ha = 0; va = 0; hs = 0; vs = 0;
                started_a = 1'b0; started_s = 1'b0;
                qa_pin.delete(); qa_addr.delete(); qs_pin.delete(); qs_addr.delete();
                cur_act_a <= 1'b0; cur_act_s <= 1'b0;
            end else begin
                if (!started_a) begin
                    for (int i = 0; i < LAT_A - 1; i++) qa_pin.push_back(IDLE);
                    for (int i = 0; i < LAT_S - 1; i++) qs_pin.push_back(IDLE);
                    started_a = 1'b1; started_s = 1'b1;
                end
                e = model(TA, ha, va);
                qa_pin.push_back(e); qa_addr.push_back(e); cur_act_a <= e.act;
                e = model(TS, hs, vs);
                qs_pin.push_back(e); qs_addr.push_back(e); cur_act_s <= e.act;
                if (ha == 799) begin ha = 0; va = (va == 524) ? 0 : va + 1; end
                else ha = ha + 1;
                if (hs == 15) begin hs = 0; vs = (vs == 7) ? 0 : vs + 1; end
                else hs = hs + 1;
            end
        end
    end

    // Monitor: pops and compares every clock, plus run-length and boundary checks.
    initial begin
        exp_t        ep, ea;
        int          hs_run_a, addr_run_a, pix_a, fs_cnt_a;
        int          hs_run_s, vs_run_s, cyc_s, fs_last_s;
        logic [18:0] addr_prev_a;
        logic        final_done;
        hs_run_a = 0; addr_run_a = 0; pix_a = -1; fs_cnt_a = 0; addr_prev_a = '1;
        hs_run_s = 0; vs_run_s = 0; cyc_s = 0; fs_last_s = -1; final_done = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                chk("rst_addr_a", addr_a, 0);  chk("rst_rgb_a", {r_a, g_a, b_a}, 0);
                chk("rst_hs_a", hs_a, 1);      chk("rst_vs_a", vs_a, 1);
                chk("rst_fs_a", fs_a, 0);
                chk("rst_addr_s", addr_s, 0);  chk("rst_rgb_s", {r_s, g_s, b_s}, 0);
                chk("rst_sync_s", {hs_s, vs_s, fs_s}, 3'b110);
                hs_run_a = 0; addr_run_a = 0; pix_a = -1; addr_prev_a = '1;
                hs_run_s = 0; vs_run_s = 0; cyc_s = 0; fs_last_s = -1;
            end else if (started_a) begin
                if (qa_pin.size() == 0 || qa_addr.size() == 0 || qs_pin.size() == 0 || qs_addr.size() == 0) begin
                    chk("queue_underflow", 1, 0);
                end else begin
                    ep = qa_pin.pop_front(); ea = qa_addr.pop_front();
                    chk("a_addr", addr_a, ea.addr);
                    chk("a_r", r_a, ep.r); chk("a_g", g_a, ep.g); chk("a_b", b_a, ep.b);
                    chk("a_hsync", hs_a, ep.hs); chk("a_vsync", vs_a, ep.vs);
                    chk("a_frame_start", fs_a, ep.fs);
                    ep = qs_pin.pop_front(); ea = qs_addr.pop_front();
                    chk("s_addr", addr_s, ea.addr);
                    chk("s_r", r_s, ep.r); chk("s_g", g_s, ep.g); chk("s_b", b_s, ep.b);
                    chk("s_hsync", hs_s, ep.hs); chk("s_vsync", vs_s, ep.vs);
                    chk("s_frame_start", fs_s, ep.fs);
                end
                if (!hs_a) hs_run_a++;
                else begin
                    if (hs_run_a != 0) chk("a_hsync_len", hs_run_a, 96);
                    hs_run_a = 0;
                end
                if (addr_a == addr_prev_a) addr_run_a++;
                else begin
                    if (addr_prev_a == 19'd639 && addr_a == 19'd640) chk("a_addr_hold_639", addr_run_a, 161);
                    addr_run_a = 1;
                end
                addr_prev_a = addr_a;
                if (fs_a) begin pix_a = 0; fs_cnt_a++; end
                else if (pix_a >= 0) pix_a++;
                if (pix_a == 5) chk("a_pixel_5_0_rgb", {r_a, g_a, b_a}, 12'h005);
                if (!hs_s) hs_run_s++;
                else begin
                    if (hs_run_s != 0) chk("s_hsync_len", hs_run_s, 3);
                    hs_run_s = 0;
                end
                if (!vs_s) vs_run_s++;
                else begin
                    if (vs_run_s != 0) chk("s_vsync_len", vs_run_s, 32);
                    vs_run_s = 0;
                end
                cyc_s++;
                if (fs_s) begin
                    if (fs_last_s >= 0) chk("s_frame_period", cyc_s - fs_last_s, 128);
                    fs_last_s = cyc_s;
                end
            end
            if (finishing && !final_done) begin
                chk("a_frame_pulses", fs_cnt_a, 2);
                final_done = 1'b1;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        finishing = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1925) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) @(posedge clk);
        #2 finishing = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
        $finish;
    end

endmodule
